operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1): the decode-side handshake.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd (inputs, ADDR_WIDTH each), and in_rd_wen (input, 1): the instruction's register fields.
REQ-007 SHALL have regfile read ports raddr1, raddr2 (outputs, ADDR_WIDTH), ren (output, 1), and rdata1, rdata2 (inputs, DATA_WIDTH), with a combinational read return.
REQ-008 SHALL have writeback ports wb_valid (input, 1), wb_rd (input, ADDR_WIDTH), wb_data (input, DATA_WIDTH); these are the same values that drive the regfile write port.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_op1, out_op2 (outputs, DATA_WIDTH), out_rd (output, ADDR_WIDTH), out_rd_wen (output, 1).
REQ-010 SHALL have ports flush (input, 1), a pipeline kill, and stall_cnt (output, 32), a count of hazard-stall cycles.

Function
REQ-011 SHALL drive raddr1=in_rs1, raddr2=in_rs2, and ren=in_valid combinationally.
REQ-012 SHALL keep a 2**ADDR_WIDTH-bit busy scoreboard; bit 0 SHALL always read 0.
REQ-013 SHALL define hazard = a source rsN!=0 with busy[rsN] not resolved this cycle, OR (in_rd_wen and in_rd!=0 and busy[in_rd] and not cleared this cycle).
REQ-014 SHALL drive in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-015 SHALL, on accept (in_valid & in_ready), register operands, rd, and rd_wen into the output stage and set out_valid the next cycle (1-cycle latency).
REQ-016 SHALL select each operand as follows: 0 if rsN==0; else wb_data if resolved by bypass (REQ-025); else rdataN.
REQ-017 SHALL clear busy[wb_rd] when wb_valid & wb_rd!=0.
REQ-018 SHALL set busy[in_rd] on accept with in_rd_wen & in_rd!=0.
REQ-019 SHALL let set win when set and clear of the same index coincide.
REQ-020 SHALL clear out_valid when out_valid & out_ready and no new accept occurs; an accept in the same cycle SHALL overwrite the stage.
REQ-021 SHALL hold the output stage stable while out_valid & !out_ready.
REQ-022 SHALL, on flush, clear out_valid, clear busy[out_rd] if out_valid & out_rd_wen, and accept nothing that cycle.
REQ-023 SHALL increment stall_cnt by 1 in each cycle with in_valid & hazard, wrapping modulo 2**32.

Reset
REQ-024 SHALL, while rst is high, clear out_valid, out_op1, out_op2, out_rd, out_rd_wen, all busy bits, and stall_cnt, and hold in_ready=0; rst SHALL override flush, wb, and accept, including mid-operation.

Configuration
REQ-025 SHALL, with OPFETCH_WB_BYPASS_EN defined, treat a busy source as resolved when wb_valid & wb_rd==rsN, and forward wb_data.
REQ-026 SHALL, without OPFETCH_WB_BYPASS_EN, never treat a busy source as resolved in the writeback cycle; the hazard SHALL persist until the cycle after the clear, and operands SHALL come only from rdataN or 0.

Structure
REQ-027 SHALL place ADDR_WIDTH/DATA_WIDTH defaults and the NUM_REGS constant in shared package core_pkg.
REQ-028 SHALL implement the busy bit-vector with its set/clear/priority logic as sub-module opfetch_scoreboard.

Verification
REQ-029 SHALL cover this case: accept rs1=3, rs2=0 with rdata1=0x11 -> next cycle out_valid=1, out_op1=0x11, out_op2=0.
REQ-030 SHALL cover this case: accept rd=5 (wen); next instruction uses rs1=5 -> in_ready=0 and stall_cnt increments each cycle until wb_valid, wb_rd=5, wb_data=0xAB.
REQ-031 SHALL cover this case: in the REQ-030 wb cycle with OPFETCH_WB_BYPASS_EN -> accept that cycle with out_op1=0xAB; without the macro -> accept exactly one cycle later with rdata1.
REQ-032 SHALL cover this case: out_ready=0 with out_valid=1 -> outputs stable, in_ready=0; raise out_ready -> back-to-back accept with no bubble.
REQ-033 SHALL cover this case: accept rd=7 then flush -> out_valid=0, busy[7]=0, and a reader of rs1=7 accepts with no stall.
REQ-034 SHALL cover this case: rst asserted with out_valid=1 and busy bits set -> next cycle all outputs 0, stall_cnt=0, no busy bits set.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants: default register-index and operand widths, and register count.
package core_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int NUM_REGS           = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction
endpackage

// File: rtl/opfetch_scoreboard.sv
// Busy bit per architectural register: set on issue, cleared by writeback or flush; set wins.
// Updates on the rising edge; register 0 never reads busy.
module opfetch_scoreboard
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_en,
    input  logic [ADDR_WIDTH-1:0]         set_idx,
    input  logic                          wb_clr_en,
    input  logic [ADDR_WIDTH-1:0]         wb_clr_idx,
    input  logic                          flush_clr_en,
    input  logic [ADDR_WIDTH-1:0]         flush_clr_idx,
    output logic [(1<<ADDR_WIDTH)-1:0]    busy
);
    localparam int NREGS = num_regs(ADDR_WIDTH);

    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (wb_clr_en)
            busy_nxt[wb_clr_idx] = 1'b0;
        if (flush_clr_en)
            busy_nxt[flush_clr_idx] = 1'b0;
        // applied last so a new writer survives a same-cycle clear of its index
        if (set_en)
            busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read + busy-scoreboard hazard stall, 1-cycle latency into the output stage.
// in_ready drops on output backpressure, hazard or flush; OPFETCH_WB_BYPASS_EN forwards wb_data to sources.
module operand_fetch
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    output logic [ADDR_WIDTH-1:0] raddr1,
    output logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_wen,
    input  logic                  flush,
    output logic [31:0]           stall_cnt
);
    localparam int NREGS = num_regs(ADDR_WIDTH);

    logic [NREGS-1:0]      busy;
    logic                  fwd1, fwd2;
    logic                  src1_haz, src2_haz, rd_haz, hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1_sel, op2_sel;

    assign raddr1 = in_rs1;
    assign raddr2 = in_rs2;
    assign ren    = in_valid;

`ifdef OPFETCH_WB_BYPASS_EN
    assign fwd1 = wb_valid && (wb_rd == in_rs1);
    assign fwd2 = wb_valid && (wb_rd == in_rs2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign src1_haz = (in_rs1 != '0) && busy[in_rs1] && !fwd1;
    assign src2_haz = (in_rs2 != '0) && busy[in_rs2] && !fwd2;
    // a pending writer to rd retiring this cycle frees rd for the new writer
    assign rd_haz   = in_rd_wen && (in_rd != '0) && busy[in_rd] &&
                      !(wb_valid && (wb_rd == in_rd));
    assign hazard   = src1_haz || src2_haz || rd_haz;

    assign in_ready = !rst && (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    assign op1_sel = (in_rs1 == '0) ? '0 : (fwd1 ? wb_data : rdata1);
    assign op2_sel = (in_rs2 == '0) ? '0 : (fwd2 ? wb_data : rdata2);

    opfetch_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en        (accept && in_rd_wen),
        .set_idx       (in_rd),
        .wb_clr_en     (wb_valid),
        .wb_clr_idx    (wb_rd),
        .flush_clr_en  (flush && out_valid && out_rd_wen),
        .flush_clr_idx (out_rd),
        .busy          (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_rd     <= '0;
            out_rd_wen <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_op1    <= op1_sel;
            out_op2    <= op2_sel;
            out_rd     <= in_rd;
            out_rd_wen <= in_rd_wen;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && hazard)
            stall_cnt <= stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed hazard/flush/reset cases, then random traffic.
// Define OPFETCH_WB_BYPASS_EN for both DUT and bench to exercise the forwarding variant.
module tb_operand_fetch;
    import core_pkg::*;

    localparam int AW = DEFAULT_ADDR_WIDTH;
    localparam int DW = DEFAULT_DATA_WIDTH;
`ifdef OPFETCH_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic          in_rd_wen = 1'b0;
    logic [AW-1:0] raddr1, raddr2;
    logic          ren;
    logic [DW-1:0] rdata1, rdata2;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_op1, out_op2;
    logic [AW-1:0] out_rd;
    logic          out_rd_wen;
    logic          flush = 1'b0;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .raddr1(raddr1), .raddr2(raddr2), .ren(ren),
        .rdata1(rdata1), .rdata2(rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    // Register file contents as the architecture sees them, combinational read.
    logic [DW-1:0] regs [NUM_REGS];
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    typedef struct packed {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [AW-1:0] rd;
        logic          wen;
    } item_t;

    item_t         exp_q[$];
    logic [AW-1:0] wbq[$];
    bit            stg_vld = 1'b0;
    logic [AW-1:0] stg_rd = '0;
    bit            stg_wen = 1'b0;
    int unsigned   m_stall = 0;
    int            checks = 0;
    int            errors = 0;
    item_t         mon_it;
    bit            rdy;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A register has an in-flight writer if the output stage or the writeback queue holds one.
    function automatic bit inflight(input logic [AW-1:0] r);
        if (r == '0) return 1'b0;
        if (stg_vld && stg_wen && stg_rd == r) return 1'b1;
        foreach (wbq[i]) if (wbq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] operand(input logic [AW-1:0] rs, input bit wbv,
                                             input logic [AW-1:0] wbr, input logic [DW-1:0] wbd);
        if (rs == '0) return '0;
        if (BYPASS && wbv && wbr == rs) return wbd;
        return regs[rs];
    endfunction

    task automatic cycle(input bit r, input bit v, input int rs1, input int rs2, input int rd,
                         input bit wen, input bit wbv, input int wbrd, input logic [DW-1:0] wbd,
                         input bit fl, input bit ordy, output bit rdy_o);
        logic [AW-1:0] a1, a2, ad, aw;
        bit   h, exp_rdy, acc;
        item_t it;
        a1 = AW'(rs1); a2 = AW'(rs2); ad = AW'(rd); aw = AW'(wbrd);
        @(negedge clk);
        rst = r; in_valid = v; in_rs1 = a1; in_rs2 = a2; in_rd = ad; in_rd_wen = wen;
        wb_valid = wbv; wb_rd = aw; wb_data = wbd; flush = fl; out_ready = ordy;
        #3;
        rdy_o = in_ready;
        h = (inflight(a1) && !(BYPASS && wbv && aw == a1)) ||
            (inflight(a2) && !(BYPASS && wbv && aw == a2)) ||
            (wen && inflight(ad) && !(wbv && aw == ad));
        exp_rdy = !r && (!stg_vld || ordy) && !h && !fl;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, stg_vld);
        acc = v && exp_rdy;
        it.op1 = operand(a1, wbv, aw, wbd);
        it.op2 = operand(a2, wbv, aw, wbd);
        it.rd  = ad;
        it.wen = wen;
        @(posedge clk);
        #1;
        if (wbv) regs[aw] = wbd;
        if (r) begin
            stg_vld = 1'b0; wbq.delete(); exp_q.delete(); m_stall = 0;
        end else begin
            if (v && h) m_stall++;
            if (wbv) begin
                for (int i = 0; i < wbq.size(); i++)
                    if (wbq[i] == aw) begin wbq.delete(i); break; end
            end
            if (fl) begin
                if (stg_vld) void'(exp_q.pop_back());
                stg_vld = 1'b0;
            end else begin
                if (stg_vld && ordy && stg_wen && stg_rd != '0) wbq.push_back(stg_rd);
                if (acc) begin
                    stg_vld = 1'b1; stg_rd = ad; stg_wen = wen; exp_q.push_back(it);
                end else if (ordy) begin
                    stg_vld = 1'b0;
                end
            end
        end
    endtask

    // Monitor: every output transfer is checked against the oldest expected instruction.
    always begin
        @(negedge clk);
        #4;
        if (!rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected: got output op1=%0h with nothing expected", out_op1);
            end else begin
                mon_it = exp_q.pop_front();
                chk("out_op1", out_op1, mon_it.op1);
                chk("out_op2", out_op2, mon_it.op2);
                chk("out_rd", DW'(out_rd), DW'(mon_it.rd));
                chk("out_rd_wen", DW'(out_rd_wen), DW'(mon_it.wen));
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        regs[1] = 32'h1111_0001;
        regs[2] = 32'h2222_0002;
        regs[3] = 32'h0000_0011;

        // reset state, with a request pending
        cycle(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
        chk("rst_in_ready", rdy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // simple read, rs2=0 reads as zero
        cycle(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
        chk("read_rdy", rdy, 1);
        chk("read_valid", out_valid, 1);
        chk("read_op1", out_op1, 32'h11);
        chk("read_op2", out_op2, 0);

        // RAW hazard on r5 stalls until writeback
        cycle(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, rdy);
        chk("wr5_rdy", rdy, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
            chk("raw_stall_rdy", rdy, 0);
        end
        chk("raw_stall_cnt", stall_cnt, 3);
        cycle(0, 1, 5, 0, 0, 0, 1, 5, 32'hAB, 0, 1, rdy);
        chk("wb_cycle_rdy", rdy, BYPASS);
        if (!BYPASS) begin
            cycle(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
            chk("after_wb_rdy", rdy, 1);
        end
        chk("raw_op1", out_op1, 32'hAB);
        chk("raw_stall_total", stall_cnt, BYPASS ? 3 : 4);

        // backpressure holds the stage, then back-to-back accepts
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, rdy);
            chk("bp_rdy", rdy, 0);
            chk("bp_op1_stable", out_op1, 32'hAB);
        end
        cycle(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, rdy);
        chk("b2b_rdy0", rdy, 1);
        chk("b2b_op1_0", out_op1, 32'h1111_0001);
        cycle(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, rdy);
        chk("b2b_rdy1", rdy, 1);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_op1_1", out_op1, 32'h2222_0002);
        chk("b2b_op2_1", out_op2, 32'h1111_0001);

        // flush kills the r7 writer and frees r7
        cycle(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 1, rdy);
        chk("wr7_rdy", rdy, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
        chk("flush_valid", out_valid, 0);
        cycle(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
        chk("flush_no_stall_rdy", rdy, 1);
        chk("flush_stall_cnt", stall_cnt, BYPASS ? 3 : 4);

        // reset mid-operation with a busy register and a full stage
        cycle(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1, rdy);
        cycle(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
        chk("pre_rst_valid", out_valid, 1);
        cycle(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
        chk("mid_rst_rdy", rdy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_op1", out_op1, 0);
        chk("mid_rst_op2", out_op2, 0);
        chk("mid_rst_rd", DW'(out_rd), 0);
        chk("mid_rst_wen", DW'(out_rd_wen), 0);
        chk("mid_rst_stall", stall_cnt, 0);
        cycle(0, 1, 9, 0, 9, 1, 0, 0, 0, 0, 1, rdy);
        chk("post_rst_rdy", rdy, 1);

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            bit  wbv;
            int  wbr;
            wbv = 1'b0; wbr = 0;
            if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wbv = 1'b1; wbr = int'(wbq[0]);
            end
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), wbv, wbr, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rdy);
        end

        // drain outstanding work, bounded
        for (int n = 0; n < 40 && (wbq.size() > 0 || stg_vld); n++) begin
            bit wbv;
            int wbr;
            wbv = wbq.size() > 0;
            wbr = wbv ? int'(wbq[0]) : 0;
            cycle(0, 0, 0, 0, 0, 0, wbv, wbr, $urandom, 0, 1, rdy);
        end
        chk("final_stall_cnt", stall_cnt, m_stall);
        chk("final_pending_outputs", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
